hps_reset_sequencer: RTL and testbench

HPS_RESET_SEQUENCER -- requirements
Module: hps_reset_sequencer

---
 rtl/hps_reset_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_hps_reset_sequencer.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hps_reset_sequencer.sv
// HPS reset request sequencer.
// Synchronizes three asynchronous request levels (cold, warm, debug), latches
// their rising edges as pending requests, and issues one active-low f2h reset
// request pulse at a time. Each pulse is followed by a holdoff dead time.
// Requests are accepted only while the HPS-to-FPGA reset is released.
module hps_reset_sequencer #(
    parameter int COLD_PULSE  = 6,
    parameter int WARM_PULSE  = 2,
    parameter int DEBUG_PULSE = 32,
    parameter int HOLDOFF     = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req_in,
    input  logic       hps_fpga_reset_n,
    output logic       cold_req_n,
    output logic       warm_req_n,
    output logic       debug_req_n,
    output logic       busy,
    output logic [1:0] last_cause,
    output logic [7:0] req_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    // Counter load values are "cycles - 1": the load cycle is the first cycle.
    localparam logic [15:0] COLD_LOAD   = 16'(COLD_PULSE - 1);
    localparam logic [15:0] WARM_LOAD   = 16'(WARM_PULSE - 1);
    localparam logic [15:0] DEBUG_LOAD  = 16'(DEBUG_PULSE - 1);
    localparam logic [15:0] HOLD_LOAD   = (HOLDOFF > 0) ? 16'(HOLDOFF - 1) : 16'd0;
    localparam bit          HAS_HOLDOFF = (HOLDOFF > 0);

    logic [SYNC_STAGES-1:0][2:0] sync_r;
    logic [2:0]  prev_r;
    logic [2:0]  edge_r;
    logic [2:0]  pending_r;
    logic [2:0]  pending_s;
    logic [2:0]  clear_s;
    state_t      state_r;
    state_t      state_s;
    logic [15:0] cnt_r;
    logic [15:0] cnt_s;
    logic        cold_r;
    logic        cold_s;
    logic        warm_r;
    logic        warm_s;
    logic        debug_r;
    logic        debug_s;
    logic        busy_r;
    logic        busy_s;
    logic [1:0]  cause_r;
    logic [1:0]  cause_s;
    logic [7:0]  count_r;
    logic [7:0]  count_s;
    logic [7:0]  count_inc_s;

    assign cold_req_n  = cold_r;
    assign warm_req_n  = warm_r;
    assign debug_req_n = debug_r;
    assign busy        = busy_r;
    assign last_cause  = cause_r;
    assign req_count   = count_r;

    // Saturating pulse counter increment.
    assign count_inc_s = (count_r == 8'hFF) ? 8'hFF : (count_r + 8'd1);

    // Synchronizer chain followed by a registered rising-edge detector.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= '0;
            prev_r <= 3'b000;
            edge_r <= 3'b000;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], req_in};
            prev_r <= sync_r[SYNC_STAGES-1];
            edge_r <= sync_r[SYNC_STAGES-1] & ~prev_r;
        end
    end

    // Pending requests: served bits are cleared, new edges are merged in,
    // and everything is dropped while the HPS holds its FPGA reset.
    always_comb begin
        pending_s = pending_r;
        if (!hps_fpga_reset_n) begin
            pending_s = 3'b000;
        end else begin
            pending_s = (pending_r & ~clear_s) | edge_r;
        end
    end

    // Next-state and next-output logic; outputs are registered below.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        cold_s  = 1'b1;
        warm_s  = 1'b1;
        debug_s = 1'b1;
        busy_s  = 1'b0;
        cause_s = cause_r;
        count_s = count_r;
        clear_s = 3'b000;
        case (state_r)
            ST_IDLE: begin
                if (pending_r != 3'b000) begin
                    state_s = ST_PULSE;
                    busy_s  = 1'b1;
                    count_s = count_inc_s;
                    if (pending_r[0]) begin
                        // Cold reset supersedes every other pending request.
                        clear_s = 3'b111;
                        cold_s  = 1'b0;
                        cnt_s   = COLD_LOAD;
                        cause_s = 2'd1;
                    end else if (pending_r[1]) begin
                        clear_s = 3'b010;
                        warm_s  = 1'b0;
                        cnt_s   = WARM_LOAD;
                        cause_s = 2'd2;
                    end else begin
                        clear_s = 3'b100;
                        debug_s = 1'b0;
                        cnt_s   = DEBUG_LOAD;
                        cause_s = 2'd3;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PULSE: begin
                if (cnt_r == 16'd0) begin
                    if (HAS_HOLDOFF) begin
                        state_s = ST_HOLDOFF;
                        cnt_s   = HOLD_LOAD;
                        busy_s  = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                        cnt_s   = 16'd0;
                        busy_s  = 1'b0;
                    end
                end else begin
                    cnt_s   = cnt_r - 16'd1;
                    cold_s  = cold_r;
                    warm_s  = warm_r;
                    debug_s = debug_r;
                    busy_s  = 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (cnt_r == 16'd0) begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                end else begin
                    cnt_s  = cnt_r - 16'd1;
                    busy_s = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 16'd0;
            end
        endcase
    end

    // State, counter, pending and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 16'd0;
            pending_r <= 3'b000;
            cold_r    <= 1'b1;
            warm_r    <= 1'b1;
            debug_r   <= 1'b1;
            busy_r    <= 1'b0;
            cause_r   <= 2'd0;
            count_r   <= 8'd0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            pending_r <= pending_s;
            cold_r    <= cold_s;
            warm_r    <= warm_s;
            debug_r   <= debug_s;
            busy_r    <= busy_s;
            cause_r   <= cause_s;
            count_r   <= count_s;
        end
    end

endmodule

// File: tb/tb_hps_reset_sequencer.sv
// Self-checking bench for hps_reset_sequencer: a monitor records every
// observed request pulse (cause, start cycle, width) into a queue, and each
// scenario pushes the pulses it expects and compares them in order.
module tb_hps_reset_sequencer;

    typedef struct {
        logic [2:0] vec;
        int         start;
        int         width;
    } pulse_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] req_in = 3'b000;
    logic [2:0] req_in2 = 3'b000;
    logic       gate = 1'b1;
    logic       cold_n, warm_n, debug_n, busy;
    logic [1:0] last_cause;
    logic [7:0] req_count;
    logic       cold_n2, warm_n2, debug_n2, busy2;
    logic [1:0] last_cause2;
    logic [7:0] req_count2;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pulses2  = 0;

    pulse_t exp_q[$];
    pulse_t obs_q[$];

    always #5 clk = ~clk;

    // Posedge counter; read on negedges as the cycle stamp.
    always @(posedge clk) cyc <= cyc + 1;

    hps_reset_sequencer u_dut (
        .clk              (clk),
        .reset            (reset),
        .req_in           (req_in),
        .hps_fpga_reset_n (gate),
        .cold_req_n       (cold_n),
        .warm_req_n       (warm_n),
        .debug_req_n      (debug_n),
        .busy             (busy),
        .last_cause       (last_cause),
        .req_count        (req_count)
    );

    hps_reset_sequencer #(
        .COLD_PULSE  (1),
        .WARM_PULSE  (1),
        .DEBUG_PULSE (1),
        .HOLDOFF     (0),
        .SYNC_STAGES (2)
    ) u_dut2 (
        .clk              (clk),
        .reset            (reset),
        .req_in           (req_in2),
        .hps_fpga_reset_n (gate),
        .cold_req_n       (cold_n2),
        .warm_req_n       (warm_n2),
        .debug_req_n      (debug_n2),
        .busy             (busy2),
        .last_cause       (last_cause2),
        .req_count        (req_count2)
    );

    function automatic pulse_t mk(input logic [2:0] v, input int s, input int w);
        pulse_t p;
        p.vec   = v;
        p.start = s;
        p.width = w;
        return p;
    endfunction

    // Pulse monitor for the default-parameter instance.
    logic [2:0] cur_vec = 3'b000;
    int         cur_start = 0;
    int         cur_width = 0;
    always @(negedge clk) begin
        logic [2:0] low_v;
        low_v = ~{debug_n, warm_n, cold_n};
        if (cur_vec != 3'b000 && low_v !== cur_vec) begin
            obs_q.push_back(mk(cur_vec, cur_start, cur_width));
            cur_vec = 3'b000;
        end
        if (low_v != 3'b000) begin
            if (cur_vec == 3'b000) begin
                cur_vec   = low_v;
                cur_start = cyc;
                cur_width = 1;
            end else begin
                cur_width = cur_width + 1;
            end
        end
    end

    // Falling-edge counter for the second instance's cold request.
    logic prev_c2 = 1'b1;
    always @(negedge clk) begin
        if (prev_c2 === 1'b1 && cold_n2 === 1'b0) pulses2 = pulses2 + 1;
        prev_c2 = cold_n2;
    end

    task automatic do_reset();
        req_in  = 3'b000;
        req_in2 = 3'b000;
        gate    = 1'b1;
        reset   = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        exp_q.delete();
        obs_q.delete();
    endtask

    // Counts cycles with busy high until it falls; -1 if it never does.
    task automatic wait_busy_done(output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (busy === 1'b1) begin
                cycles++;
                seen = 1'b1;
            end else if (seen) begin
                return;
            end
        end
        cycles = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_in = 3'b000;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({cold_n, warm_n, debug_n} !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_req_n: got %b expected 111", {cold_n, warm_n, debug_n});
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        n_checks++;
        if (last_cause !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_last_cause: got %0d expected 0", last_cause);
        end
        n_checks++;
        if (req_count !== 8'd0 || req_count2 !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_req_count: got %0d/%0d expected 0/0", req_count, req_count2);
        end
        reset = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %0d pulses busy=%b expected 0 pulses busy=0", obs_q.size(), busy);
        end
    endtask

    task automatic test_warm_pulse();
        int t0, bc;
        pulse_t e, o;
        do_reset();
        req_in[1] = 1'b1;
        t0 = cyc;
        exp_q.push_back(mk(3'b010, t0 + 5, 2));
        wait_busy_done(bc);
        n_checks++;
        if (bc !== 1026) begin
            n_fail++;
            $display("FAIL warm_busy_cycles: got %0d expected 1026", bc);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 1) begin
            n_fail++;
            $display("FAIL warm_pulse_count: got %0d expected 1", obs_q.size());
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            if (o.vec !== e.vec || o.start != e.start || o.width != e.width) begin
                n_fail++;
                $display("FAIL warm_pulse: got vec=%b start=%0d width=%0d expected vec=%b start=%0d width=%0d",
                         o.vec, o.start, o.width, e.vec, e.start, e.width);
            end
        end
        n_checks++;
        if (last_cause !== 2'd2 || req_count !== 8'd1) begin
            n_fail++;
            $display("FAIL warm_status: got cause=%0d count=%0d expected cause=2 count=1", last_cause, req_count);
        end
        req_in = 3'b000;
    endtask

    task automatic test_simultaneous();
        int t0, bc;
        pulse_t e, o;
        do_reset();
        req_in = 3'b111;
        t0 = cyc;
        exp_q.push_back(mk(3'b001, t0 + 5, 6));
        wait_busy_done(bc);
        n_checks++;
        if (bc !== 1030) begin
            n_fail++;
            $display("FAIL cold_busy_cycles: got %0d expected 1030", bc);
        end
        repeat (60) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 1) begin
            n_fail++;
            $display("FAIL simul_pulse_count: got %0d expected 1", obs_q.size());
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            if (o.vec !== e.vec || o.start != e.start || o.width != e.width) begin
                n_fail++;
                $display("FAIL simul_pulse: got vec=%b start=%0d width=%0d expected vec=%b start=%0d width=%0d",
                         o.vec, o.start, o.width, e.vec, e.start, e.width);
            end
        end
        n_checks++;
        if (last_cause !== 2'd1 || req_count !== 8'd1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_status: got cause=%0d count=%0d busy=%b expected cause=1 count=1 busy=0",
                     last_cause, req_count, busy);
        end
        req_in = 3'b000;
    endtask

    task automatic test_back_to_back();
        int t0;
        pulse_t e, o;
        do_reset();
        req_in[1] = 1'b1;
        t0 = cyc;
        exp_q.push_back(mk(3'b010, t0 + 5, 2));
        repeat (3) @(negedge clk);
        req_in[2] = 1'b1;
        exp_q.push_back(mk(3'b100, t0 + 1032, 32));
        for (int i = 0; i < 3000 && obs_q.size() < 2; i++) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_pulse_count: got %0d expected 2", obs_q.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                n_checks++;
                if (o.vec !== e.vec || o.start != e.start || o.width != e.width) begin
                    n_fail++;
                    $display("FAIL b2b_pulse%0d: got vec=%b start=%0d width=%0d expected vec=%b start=%0d width=%0d",
                             k, o.vec, o.start, o.width, e.vec, e.start, e.width);
                end
            end
        end
        n_checks++;
        if (last_cause !== 2'd3 || req_count !== 8'd2) begin
            n_fail++;
            $display("FAIL b2b_status: got cause=%0d count=%0d expected cause=3 count=2", last_cause, req_count);
        end
        req_in = 3'b000;
    endtask

    task automatic test_gate();
        int t0;
        pulse_t e, o;
        do_reset();
        gate = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req_in[0] = 1'b1;
            repeat (3) @(negedge clk);
            req_in[0] = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 0 || busy !== 1'b0 || req_count !== 8'd0) begin
            n_fail++;
            $display("FAIL gate_block: got pulses=%0d busy=%b count=%0d expected 0/0/0", obs_q.size(), busy, req_count);
        end
        gate = 1'b1;
        @(negedge clk);
        req_in[2] = 1'b1;
        t0 = cyc;
        exp_q.push_back(mk(3'b100, t0 + 5, 32));
        repeat (15) @(negedge clk);
        n_checks++;
        if (debug_n !== 1'b0) begin
            n_fail++;
            $display("FAIL gate_mid_pulse: got debug_req_n=%b expected 0", debug_n);
        end
        gate = 1'b0;
        for (int i = 0; i < 100 && obs_q.size() < 1; i++) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 1) begin
            n_fail++;
            $display("FAIL gate_pulse_count: got %0d expected 1", obs_q.size());
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            if (o.vec !== e.vec || o.start != e.start || o.width != e.width) begin
                n_fail++;
                $display("FAIL gate_pulse: got vec=%b start=%0d width=%0d expected vec=%b start=%0d width=%0d",
                         o.vec, o.start, o.width, e.vec, e.start, e.width);
            end
        end
        n_checks++;
        if (req_count !== 8'd1 || last_cause !== 2'd3) begin
            n_fail++;
            $display("FAIL gate_status: got count=%0d cause=%0d expected count=1 cause=3", req_count, last_cause);
        end
        req_in = 3'b000;
        gate   = 1'b1;
    endtask

    task automatic test_reset_mid_pulse();
        int t0, t1, bc;
        pulse_t e, o;
        do_reset();
        req_in[0] = 1'b1;
        t0 = cyc;
        exp_q.push_back(mk(3'b001, t0 + 5, 3));
        repeat (7) @(negedge clk);
        n_checks++;
        if (cold_n !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_in_pulse: got cold_req_n=%b expected 0", cold_n);
        end
        reset  = 1'b1;
        req_in = 3'b000;
        @(negedge clk);
        n_checks++;
        if ({cold_n, warm_n, debug_n, busy} !== 4'b1110 || last_cause !== 2'd0 || req_count !== 8'd0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got req_n=%b busy=%b cause=%0d count=%0d expected 111/0/0/0",
                     {cold_n, warm_n, debug_n}, busy, last_cause, req_count);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs_q.size() != 1) begin
            n_fail++;
            $display("FAIL midrst_pulse_count: got %0d expected 1", obs_q.size());
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            if (o.vec !== e.vec || o.start != e.start || o.width != e.width) begin
                n_fail++;
                $display("FAIL midrst_pulse: got vec=%b start=%0d width=%0d expected vec=%b start=%0d width=%0d",
                         o.vec, o.start, o.width, e.vec, e.start, e.width);
            end
        end
        req_in[1] = 1'b1;
        t1 = cyc;
        exp_q.push_back(mk(3'b010, t1 + 5, 2));
        wait_busy_done(bc);
        n_checks++;
        if (obs_q.size() != 1 || bc != 1026) begin
            n_fail++;
            $display("FAIL midrst_rerun_count: got pulses=%0d busy=%0d expected 1/1026", obs_q.size(), bc);
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            if (o.vec !== e.vec || o.start != e.start || o.width != e.width) begin
                n_fail++;
                $display("FAIL midrst_rerun: got vec=%b start=%0d width=%0d expected vec=%b start=%0d width=%0d",
                         o.vec, o.start, o.width, e.vec, e.start, e.width);
            end
        end
        n_checks++;
        if (last_cause !== 2'd2 || req_count !== 8'd1) begin
            n_fail++;
            $display("FAIL midrst_status: got cause=%0d count=%0d expected cause=2 count=1", last_cause, req_count);
        end
        req_in = 3'b000;
    endtask

    task automatic test_saturate();
        int exp_cnt;
        do_reset();
        pulses2 = 0;
        for (int i = 1; i <= 300; i++) begin
            req_in2[0] = 1'b1;
            repeat (3) @(negedge clk);
            req_in2[0] = 1'b0;
            repeat (3) @(negedge clk);
            exp_cnt = (i > 255) ? 255 : i;
            if (i == 1 || i == 100 || i == 255 || i == 256 || i == 300) begin
                n_checks++;
                if (req_count2 !== 8'(exp_cnt)) begin
                    n_fail++;
                    $display("FAIL sat_count_%0d: got %0d expected %0d", i, req_count2, exp_cnt);
                end
            end
        end
        n_checks++;
        if (pulses2 != 300 || busy2 !== 1'b0 || last_cause2 !== 2'd1) begin
            n_fail++;
            $display("FAIL sat_pulses: got %0d busy=%b cause=%0d expected 300/0/1", pulses2, busy2, last_cause2);
        end
    endtask

    initial begin
        test_reset();
        test_warm_pulse();
        test_simultaneous();
        test_back_to_back();
        test_gate();
        test_reset_mid_pulse();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
